program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/pisa_loader_pkg.sv | 25 ++
 rtl/loader_timeout.sv | 39 +++
 rtl/program_loader.sv | 172 +++++++++++++++++
 tb/tb_program_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pisa_loader_pkg.sv
// Shared types and constants for the UART program loader.
// The state enum is shared so other blocks can decode loader progress.
package pisa_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    FILL,
    READY,
    ERROR
  } loader_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [15:0] len_t;

  // States in which the host is mid-frame and the inter-byte gap is policed.
  function automatic logic frame_open(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte gap watchdog: counts idle cycles while enabled and flags
// expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed since the last clear.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = enable && (cnt_q == LIMIT);

  // Saturate at the limit so a stalled consumer of expired never sees a wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image over a byte stream, writes it into code
// memory, pads the remainder with FILL_BYTE and reports ready or error.
module program_loader
  import pisa_loader_pkg::*;
#(
  parameter int         DEPTH          = 256,
  parameter int         ADDR_W         = $clog2(DEPTH),
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] FILL_BYTE      = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              prog_ready,
  output logic              load_error,
  output logic [15:0]       load_len
);

  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [16:0] LAST_IDX = 17'(DEPTH - 1);

  loader_state_t state_q, state_d;

  len_t              len_q, len_d;
  len_t              idx_q, idx_d;
  len_t              load_len_q, load_len_d;
  logic [7:0]        sum_q, sum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;

  logic       sync_seen;
  len_t       frame_len;
  logic       len_ok;
  logic       last_data;
  logic [7:0] csum_total;
  logic       csum_ok;
  logic       fill_needed;
  logic       fill_last;
  logic       expired;

  assign sync_seen   = byte_valid && (byte_in == SYNC_BYTE);
  assign frame_len   = {byte_in, len_q[7:0]};
  assign len_ok      = (frame_len != 16'd0) && ({1'b0, frame_len} <= DEPTH_L);
  assign last_data   = (idx_q == (len_q - 16'd1));
  assign csum_total  = sum_q + byte_in;
  assign csum_ok     = (csum_total == 8'h00);
  assign fill_needed = ({1'b0, len_q} < DEPTH_L);
  assign fill_last   = ({1'b0, idx_q} == LAST_IDX);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (frame_open(state_q)),
    .clear  (byte_valid),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A byte arriving in the same cycle as expiry wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY, ERROR: if (sync_seen) state_d = LEN_LO;
      LEN_LO: begin
        if (byte_valid)   state_d = LEN_HI;
        else if (expired) state_d = ERROR;
      end
      LEN_HI: begin
        if (byte_valid)   state_d = len_ok ? DATA : ERROR;
        else if (expired) state_d = ERROR;
      end
      DATA: begin
        if (byte_valid) begin
          if (last_data) state_d = CSUM;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      CSUM: begin
        if (byte_valid) begin
          if (!csum_ok)         state_d = ERROR;
          else if (fill_needed) state_d = FILL;
          else                  state_d = READY;
        end else if (expired) begin
          state_d = ERROR;
        end
      end
      FILL:    if (fill_last) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  // idx_q doubles as data index and fill address: it leaves DATA equal to N.
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    load_len_d = load_len_q;
    prog_ready = (state_q == READY);
    load_error = (state_q == ERROR);
    case (state_q)
      IDLE, READY, ERROR: begin
        if (sync_seen) begin
          sum_d = 8'h00;
          idx_d = 16'd0;
        end
      end
      LEN_LO: if (byte_valid) len_d = {8'h00, byte_in};
      LEN_HI: if (byte_valid) len_d = frame_len;
      DATA: begin
        if (byte_valid) begin
          mem_we_d   = 1'b1;
          mem_addr_d = idx_q[ADDR_W-1:0];
          mem_data_d = byte_in;
          sum_d      = csum_total;
          idx_d      = idx_q + 16'd1;
        end
      end
      CSUM: if (byte_valid && csum_ok) load_len_d = len_q;
      FILL: begin
        mem_we_d   = 1'b1;
        mem_addr_d = idx_q[ADDR_W-1:0];
        mem_data_d = FILL_BYTE;
        idx_d      = idx_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'h00;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      sum_q      <= 8'h00;
      load_len_q <= 16'd0;
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      load_len_q <= load_len_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign load_len = load_len_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (256-byte and 16-byte memories)
// driven by directed and random frames against a frame-level reference model.
module tb_program_loader;

  localparam int         DEPTH_A = 256;
  localparam int         DEPTH_B = 16;
  localparam int         TMO     = 100;
  localparam logic [7:0] FILL_A  = 8'h00;
  localparam logic [7:0] FILL_B  = 8'hC3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in_a, byte_in_b;
  logic        byte_valid_a, byte_valid_b;
  logic        mem_we_a, mem_we_b;
  logic [7:0]  mem_addr_a;
  logic [3:0]  mem_addr_b;
  logic [7:0]  mem_data_a, mem_data_b;
  logic        prog_ready_a, prog_ready_b;
  logic        load_error_a, load_error_b;
  logic [15:0] load_len_a, load_len_b;

  int n_cmp = 0;
  int n_err = 0;
  int exp_a[$];
  int exp_b[$];
  int last_len[2];
  bit exp_ready[2];
  bit exp_err[2];

  always #5 clk = ~clk;

  program_loader #(
    .DEPTH(DEPTH_A), .TIMEOUT_CYCLES(TMO), .FILL_BYTE(FILL_A)
  ) dut_a (
    .clk(clk), .rst(rst), .byte_in(byte_in_a), .byte_valid(byte_valid_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .prog_ready(prog_ready_a), .load_error(load_error_a), .load_len(load_len_a)
  );

  program_loader #(
    .DEPTH(DEPTH_B), .TIMEOUT_CYCLES(TMO), .FILL_BYTE(FILL_B)
  ) dut_b (
    .clk(clk), .rst(rst), .byte_in(byte_in_b), .byte_valid(byte_valid_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .prog_ready(prog_ready_b), .load_error(load_error_b), .load_len(load_len_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check any write against the model queue.
  task automatic tick();
    int e;
    @(negedge clk);
    if (mem_we_a !== 1'b0) begin
      if (exp_a.size() > 0) e = exp_a.pop_front();
      else e = 32'hFFFFF;
      check("write_a", {16'h0, mem_addr_a, mem_data_a}, e);
    end
    if (mem_we_b !== 1'b0) begin
      if (exp_b.size() > 0) e = exp_b.pop_front();
      else e = 32'hFFFFF;
      check("write_b", {20'h0, mem_addr_b, mem_data_b}, e);
    end
  endtask

  task automatic drive(input int d, input logic [7:0] b, input logic v);
    if (d == 0) begin
      byte_in_a = b;
      byte_valid_a = v;
    end else begin
      byte_in_b = b;
      byte_valid_b = v;
    end
  endtask

  function automatic logic get_we(input int d);
    return (d == 0) ? mem_we_a : mem_we_b;
  endfunction
  function automatic logic get_ready(input int d);
    return (d == 0) ? prog_ready_a : prog_ready_b;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? load_error_a : load_error_b;
  endfunction
  function automatic logic [15:0] get_len(input int d);
    return (d == 0) ? load_len_a : load_len_b;
  endfunction

  // One-cycle byte pulse; exp_we < 0 means "don't check the strobe".
  task automatic send_byte(input int d, input logic [7:0] b, input int exp_we);
    drive(d, b, 1'b1);
    tick();
    drive(d, 8'h00, 1'b0);
    if (exp_we >= 0) check("we_after_byte", {31'h0, get_we(d)}, exp_we);
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  // Model: a frame yields data writes 0..N-1 if 1<=N<=DEPTH, then fill writes
  // N..DEPTH-1 only if the data sum plus CSUM is 0 mod 256.
  task automatic send_frame(input int d, input int n, input bq_t dat,
                            input logic [7:0] csum, input int noise, input bit poke);
    int depth;
    int k;
    logic [7:0] fillb;
    logic [7:0] sum;
    logic [7:0] nb;
    logic [15:0] nl;
    bit len_ok;
    bit accept;
    int q[$];
    depth = (d == 0) ? DEPTH_A : DEPTH_B;
    fillb = (d == 0) ? FILL_A : FILL_B;
    nl = 16'(n);
    sum = 8'h00;
    len_ok = (n >= 1) && (n <= depth);
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        sum = sum + dat[i];
        q.push_back((i << 8) | int'(dat[i]));
      end
    end
    accept = len_ok && (8'(sum + csum) == 8'h00);
    if (accept) begin
      for (int a = n; a < depth; a++) q.push_back((a << 8) | int'(fillb));
    end
    if (d == 0) exp_a = q;
    else exp_b = q;

    for (int i = 0; i < noise; i++) begin
      nb = 8'($urandom_range(0, 255));
      if (nb == 8'hA5) nb = 8'h5A;
      send_byte(d, nb, 0);
      gap();
    end
    if (noise > 0) begin
      check("noise_ready", {31'h0, get_ready(d)}, {31'h0, exp_ready[d]});
      check("noise_error", {31'h0, get_err(d)}, {31'h0, exp_err[d]});
    end

    send_byte(d, 8'hA5, 0);
    check("sync_clears_ready", {31'h0, get_ready(d)}, 0);
    check("sync_clears_error", {31'h0, get_err(d)}, 0);
    gap();
    send_byte(d, nl[7:0], 0);
    gap();
    send_byte(d, nl[15:8], 0);
    if (!len_ok) begin
      check("len_reject_err", {31'h0, get_err(d)}, 1);
    end else begin
      for (int i = 0; i < n; i++) begin
        gap();
        send_byte(d, dat[i], 1);
      end
      gap();
      send_byte(d, csum, 0);
      if (accept) begin
        k = depth - n;
        for (int i = 1; i < k; i++) begin
          if (poke && i == k / 2) drive(d, 8'hA5, 1'b1);
          tick();
          drive(d, 8'h00, 1'b0);
        end
        if (k > 0) begin
          check("ready_during_fill", {31'h0, get_ready(d)}, 0);
          tick();
        end
        check("ready_after_fill", {31'h0, get_ready(d)}, 1);
        last_len[d] = n;
      end else begin
        check("csum_reject_err", {31'h0, get_err(d)}, 1);
      end
    end
    repeat (3) tick();
    check("pending_writes", (d == 0) ? exp_a.size() : exp_b.size(), 0);
    check("load_len", {16'h0, get_len(d)}, last_len[d]);
    check("ready_final", {31'h0, get_ready(d)}, {31'h0, accept});
    check("error_final", {31'h0, get_err(d)}, {31'h0, !accept});
    exp_ready[d] = accept;
    exp_err[d] = !accept;
  endtask

  initial begin
    bq_t dat;
    int n;
    logic [7:0] sum;
    logic [7:0] cs;

    rst = 1'b1;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    last_len[0] = 0;
    last_len[1] = 0;
    exp_ready = '{0, 0};
    exp_err = '{0, 0};
    repeat (3) tick();
    check("rst_we", {30'h0, mem_we_a, mem_we_b}, 0);
    check("rst_addr", {20'h0, mem_addr_a, mem_addr_b}, 0);
    check("rst_data", {16'h0, mem_data_a, mem_data_b}, 0);
    check("rst_flags", {28'h0, prog_ready_a, prog_ready_b, load_error_a, load_error_b}, 0);
    check("rst_len", {load_len_a, load_len_b}, 0);
    rst = 1'b0;
    tick();

    // 4-byte image into 256-byte memory; a byte mid-FILL must be dropped.
    dat = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0, 4, dat, 8'h56, 0, 1'b1);
    // Same frame with a wrong checksum, sent from READY.
    send_frame(0, 4, dat, 8'h57, 0, 1'b0);

    // Oversize length on the 16-byte memory, then an exactly-full image.
    dat.delete();
    send_frame(1, 17, dat, 8'h00, 0, 1'b0);
    for (int i = 0; i < 16; i++) dat.push_back(8'h01);
    send_frame(1, 16, dat, 8'hF0, 0, 1'b0);
    dat.delete();
    send_frame(1, 0, dat, 8'h00, 1, 1'b0);

    // Inter-byte timeout after one of two data bytes.
    exp_a.push_back(32'h0011);
    send_byte(0, 8'hA5, 0);
    tick();
    send_byte(0, 8'h02, 0);
    tick();
    send_byte(0, 8'h00, 0);
    tick();
    send_byte(0, 8'h11, 1);
    repeat (TMO - 1) tick();
    check("timeout_not_yet", {31'h0, load_error_a}, 0);
    tick();
    check("timeout_error", {31'h0, load_error_a}, 1);
    exp_ready[0] = 1'b0;
    exp_err[0] = 1'b1;
    dat = '{8'hA5, 8'h5B};
    send_frame(0, 2, dat, 8'h00, 1, 1'b0);

    // Reset coinciding with a data byte aborts the frame without writing.
    exp_a.push_back(32'h0021);
    send_byte(0, 8'hA5, 0);
    send_byte(0, 8'h03, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h21, 1);
    drive(0, 8'h5A, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 8'h00, 1'b0);
    check("rst_mid_data_we", {31'h0, mem_we_a}, 0);
    check("rst_mid_data_flags", {30'h0, prog_ready_a, load_error_a}, 0);
    check("rst_mid_data_len", {16'h0, load_len_a}, 0);
    last_len[0] = 0;
    last_len[1] = 0;
    exp_ready = '{0, 0};
    exp_err = '{0, 0};
    send_byte(0, 8'h33, 0);
    check("idle_after_rst", {31'h0, mem_we_a}, 0);

    // Random frames: lengths straddle 0 and DEPTH, some checksums corrupted.
    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(0, 20);
      dat.delete();
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
        dat.push_back(8'($urandom_range(0, 255)));
        sum = sum + dat[i];
      end
      cs = 8'h00 - sum;
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      send_frame(1, n, dat, cs, $urandom_range(0, 2), 1'b0);
    end
    for (int f = 0; f < 5; f++) begin
      n = (f == 4) ? $urandom_range(250, 256) : $urandom_range(1, 64);
      dat.delete();
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
        dat.push_back(8'($urandom_range(0, 255)));
        sum = sum + dat[i];
      end
      cs = 8'h00 - sum;
      if (f == 2) cs = cs ^ 8'h80;
      send_frame(0, n, dat, cs, $urandom_range(0, 1), f[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
